// File: rtl/tcdm_to_apb_bridge.sv
// ---------------------------------------------------------------------------
// tcdm_to_apb_bridge
//
// Single-port TCDM responder that converts each granted 32-bit TCDM request
// into exactly one APB3/APB4 transfer. The result comes back as a TCDM
// response. Only one transaction is in flight at a time. Requests outside the
// decoded window are answered with an error and never reach the APB side. An
// ACCESS phase that waits too long for pready is abandoned and answered with
// an error.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   tcdm_req_i            TCDM request
//   tcdm_add_i            byte address
//   tcdm_wen_i            1 = read, 0 = write
//   tcdm_wdata_i          write data
//   tcdm_be_i             byte enables
//   tcdm_gnt_o            grant (combinational, IDLE only)
//   tcdm_r_valid_o        one-cycle response strobe
//   tcdm_r_rdata_o        read data (held after r_valid drops)
//   tcdm_r_opc_o          response error (held after r_valid drops)
//   paddr_o .. pprot_o    APB requester outputs
//   pready_i, prdata_i,
//   pslverr_i             APB completer inputs
// ---------------------------------------------------------------------------
module tcdm_to_apb_bridge #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1A10_0000,
    parameter logic [ADDR_WIDTH-1:0] WINDOW_SIZE    = 32'h0010_0000,
    parameter int unsigned           TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = 32'hBADA_CCE5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    tcdm_req_i,
    input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
    input  logic                    tcdm_wen_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
    output logic                    tcdm_gnt_o,
    output logic                    tcdm_r_valid_o,
    output logic [DATA_WIDTH-1:0]   tcdm_r_rdata_o,
    output logic                    tcdm_r_opc_o,

    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic                    pwrite_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    output logic [2:0]              pprot_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i
);

    // The counter only has to represent 0 .. TIMEOUT_CYCLES-1: the cycle in
    // which it would reach TIMEOUT_CYCLES is the cycle that leaves ACCESS.
    localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   in_window;
    logic                   load_resp;
    logic                   resp_err;
    logic                   resp_is_read;
    logic [DATA_WIDTH-1:0]  resp_rdata;
    logic [ADDR_WIDTH:0]    win_lo, win_hi;

    // One extra bit so that a window ending at the top of the address space
    // does not wrap around to zero.
    assign win_lo    = {1'b0, BASE_ADDR};
    assign win_hi    = {1'b0, BASE_ADDR} + {1'b0, WINDOW_SIZE};
    assign in_window = ({1'b0, tcdm_add_i} >= win_lo) && ({1'b0, tcdm_add_i} < win_hi);

    assign pprot_o = 3'b000;

    // Next-state and grant.
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        tcdm_gnt_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                tcdm_gnt_o = tcdm_req_i;
                if (tcdm_req_i) begin
                    state_d = in_window ? SETUP : RESP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_d = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response contents, loaded on the transition into RESP. Coming from
    // IDLE means out-of-window. Leaving ACCESS without pready means timeout.
    always_comb begin
        load_resp    = (state_d == RESP) && (state_q != RESP);
        resp_is_read = (state_q == IDLE) ? tcdm_wen_i : ~pwrite_o;
        resp_err     = 1'b1;
        if ((state_q == ACCESS) && pready_i) begin
            resp_err = pslverr_i;
        end
        resp_rdata = '0;
        if (resp_is_read) begin
            resp_rdata = resp_err ? ERR_RDATA : prdata_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            psel_o         <= 1'b0;
            penable_o      <= 1'b0;
            tcdm_r_valid_o <= 1'b0;
            tcdm_r_rdata_o <= '0;
            tcdm_r_opc_o   <= 1'b0;
            paddr_o        <= '0;
            pwrite_o       <= 1'b0;
            pwdata_o       <= '0;
            pstrb_o        <= '0;
        end else begin
            state_q <= state_d;

            // APB strobes follow the next state, so they come straight from flops.
            psel_o         <= (state_d == SETUP) || (state_d == ACCESS);
            penable_o      <= (state_d == ACCESS);
            tcdm_r_valid_o <= (state_d == RESP);

            // Only cycles spent waiting in ACCESS count; anything else clears.
            if ((state_q == ACCESS) && (state_d == ACCESS)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end else begin
                cnt_q <= '0;
            end

            // Capture the request at grant. The APB fields stay frozen until
            // the next granted in-window request.
            if ((state_q == IDLE) && tcdm_req_i && in_window) begin
                paddr_o  <= tcdm_add_i;
                pwrite_o <= ~tcdm_wen_i;
                pwdata_o <= tcdm_wen_i ? '0 : tcdm_wdata_i;
                pstrb_o  <= tcdm_wen_i ? '0 : tcdm_be_i;
            end

            if (load_resp) begin
                tcdm_r_opc_o   <= resp_err;
                tcdm_r_rdata_o <= resp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_tcdm_to_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_tcdm_to_apb_bridge
//
// Self-checking bench for tcdm_to_apb_bridge with TIMEOUT_CYCLES = 4.
// A directed vector table and randomized transactions are each compared
// against a transaction-level reference model. Hand-written sequences cover
// back-to-back requests, a late pready after a timeout, and reset
// during ACCESS. An APB responder answers each transfer after a programmed
// number of wait states. A monitor flags psel dropping before an access
// completed or timed out.
// ---------------------------------------------------------------------------
module tb_tcdm_to_apb_bridge;

    localparam int          TO   = 4;
    localparam logic [31:0] BASE = 32'h1A10_0000;
    localparam logic [31:0] WIN  = 32'h0010_0000;
    localparam logic [31:0] ERR  = 32'hBADA_CCE5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_opc;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    // Responder configuration, written by the stimulus process.
    int          resp_waits  = 0;
    logic [31:0] resp_prdata = '0;
    logic        resp_slverr = 1'b0;
    logic        late_pulse  = 1'b0;

    always #5 clk = ~clk;

    tcdm_to_apb_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .BASE_ADDR      (BASE),
        .WINDOW_SIZE    (WIN),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tcdm_req_i     (req),
        .tcdm_add_i     (add),
        .tcdm_wen_i     (wen),
        .tcdm_wdata_i   (wdata),
        .tcdm_be_i      (be),
        .tcdm_gnt_o     (gnt),
        .tcdm_r_valid_o (r_valid),
        .tcdm_r_rdata_o (r_rdata),
        .tcdm_r_opc_o   (r_opc),
        .paddr_o        (paddr),
        .pwrite_o       (pwrite),
        .psel_o         (psel),
        .penable_o      (penable),
        .pwdata_o       (pwdata),
        .pstrb_o        (pstrb),
        .pprot_o        (pprot),
        .pready_i       (pready),
        .prdata_i       (prdata),
        .pslverr_i      (pslverr)
    );

    typedef struct {
        logic [31:0] add;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;   // wait states before pready; >= TO never answers
        logic [31:0] prdata;
        logic        slverr;
    } txn_t;

    typedef struct {
        int          lat;     // cycles from gnt to r_valid
        logic        opc;
        logic [31:0] rdata;
        int          acc;     // number of ACCESS cycles on the bus
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: outcome follows from window membership,
    // wait states vs. timeout, and slave error.
    function automatic exp_t model(input txn_t t);
        exp_t   e;
        longint a      = longint'(t.add);
        bit     in_win = (a >= longint'(BASE)) && (a < longint'(BASE) + longint'(WIN));
        if (!in_win) begin
            e.lat = 1; e.opc = 1'b1; e.acc = 0;
        end else if (t.waits >= TO) begin
            e.lat = 2 + TO; e.opc = 1'b1; e.acc = TO;
        end else begin
            e.lat = 3 + t.waits; e.opc = t.slverr; e.acc = t.waits + 1;
        end
        if (!t.wen)      e.rdata = '0;
        else if (e.opc)  e.rdata = ERR;
        else             e.rdata = t.prdata;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [31:0] a, input logic w, input logic [31:0] wd,
                                 input logic [3:0] b, input int ws, input logic [31:0] rd,
                                 input logic se, input int lat, input logic opc,
                                 input logic [31:0] rdat, input int acc);
        vec_t v;
        v.t = '{add: a, wen: w, wdata: wd, be: b, waits: ws, prdata: rd, slverr: se};
        v.e = '{lat: lat, opc: opc, rdata: rdat, acc: acc};
        return v;
    endfunction

    // APB completer: pready after resp_waits wait states of ACCESS.
    initial begin
        int k = 0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                pready = 1'b0; pslverr = 1'b0; k = 0;
            end else if (psel && penable) begin
                if (k == resp_waits) begin
                    pready = 1'b1; prdata = resp_prdata; pslverr = resp_slverr; k = 0;
                end else begin
                    pready = 1'b0; pslverr = 1'b0; prdata = $urandom; k++;
                end
            end else begin
                pready = late_pulse; pslverr = 1'b0; k = 0;
            end
        end
    end

    // Bus monitor: psel may only fall after pready or after a full timeout.
    initial begin
        logic prev_psel  = 1'b0;
        logic prev_pen   = 1'b0;
        logic prev_ready = 1'b0;
        int   nrdy       = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_psel = 1'b0; prev_pen = 1'b0; prev_ready = 1'b0; nrdy = 0;
            end else begin
                if (prev_psel && !psel)
                    check("psel_drop_legal", {31'd0, prev_pen && (prev_ready || nrdy == TO)}, 32'd1);
                if (!psel) nrdy = 0;
                else if (penable && !pready) nrdy++;
                prev_psel = psel; prev_pen = penable; prev_ready = pready;
            end
        end
    end

    // Issue one request (req dropped after grant) and compare what follows.
    task automatic run_and_check(input string tag, input txn_t t, input exp_t e);
        int          lat = -1, acc = 0, first_psel = -1, first_pen = -1, rv_cnt = 0;
        logic        gnt0 = 1'b0, stable = 1'b1, a_pwrite = 1'b0, rv_opc = 1'b0;
        logic        hold_opc = ~e.opc;
        logic [31:0] a_paddr = '0, a_pwdata = '0, rv_rdata = '0;
        logic [31:0] hold_rdata = ~e.rdata;
        logic [3:0]  a_pstrb = '0;
        resp_waits = t.waits; resp_prdata = t.prdata; resp_slverr = t.slverr;
        @(posedge clk); #1;
        req = 1'b1; add = t.add; wen = t.wen; wdata = t.wdata; be = t.be;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) gnt0 = gnt;
            if (psel && first_psel < 0) first_psel = c;
            if (psel && penable) begin
                acc++;
                if (first_pen < 0) begin
                    first_pen = c; a_paddr = paddr; a_pwrite = pwrite;
                    a_pstrb = pstrb; a_pwdata = pwdata;
                end else if (paddr !== a_paddr || pwrite !== a_pwrite ||
                             pstrb !== a_pstrb || pwdata !== a_pwdata) begin
                    stable = 1'b0;
                end
            end
            if (r_valid) begin
                rv_cnt++;
                if (lat < 0) begin lat = c; rv_rdata = r_rdata; rv_opc = r_opc; end
            end
            if (lat >= 0 && c == lat + 1) begin
                hold_rdata = r_rdata; hold_opc = r_opc;
                break;
            end
            @(posedge clk); #1;
            if (c == 0) begin
                req = 1'b0; add = ~t.add; wen = ~t.wen; wdata = ~t.wdata; be = ~t.be;
            end
        end
        check({tag, " gnt"},        {31'd0, gnt0},    32'd1);
        check({tag, " latency"},    lat,              e.lat);
        check({tag, " rvalid_cnt"}, rv_cnt,           32'd1);
        check({tag, " r_opc"},      {31'd0, rv_opc},  {31'd0, e.opc});
        check({tag, " r_rdata"},    rv_rdata,         e.rdata);
        check({tag, " hold_opc"},   {31'd0, hold_opc}, {31'd0, e.opc});
        check({tag, " hold_rdata"}, hold_rdata,       e.rdata);
        check({tag, " access_cyc"}, acc,              e.acc);
        if (e.acc > 0) begin
            check({tag, " psel_cyc"},   first_psel,          32'd1);
            check({tag, " pen_cyc"},    first_pen,           32'd2);
            check({tag, " paddr"},      a_paddr,             t.add);
            check({tag, " pwrite"},     {31'd0, a_pwrite},   {31'd0, ~t.wen});
            check({tag, " pstrb"},      {28'd0, a_pstrb},    t.wen ? 32'd0 : {28'd0, t.be});
            check({tag, " apb_stable"}, {31'd0, stable},     32'd1);
            if (!t.wen) check({tag, " pwdata"}, a_pwdata, t.wdata);
        end else begin
            check({tag, " no_psel"}, first_psel, -1);
        end
    endtask

    vec_t tbl[11];

    initial begin
        logic [7:0] gnt_e, psel_e, rv_e;
        txn_t       t;

        tbl[0]  = mkv(32'h1A10_0010, 1'b0, 32'hCAFE_F00D, 4'hF, 0,   32'h0,         1'b0, 3, 1'b0, 32'h0,         1);
        tbl[1]  = mkv(32'h1A10_0004, 1'b1, 32'h0,         4'h0, 3,   32'h1234_5678, 1'b0, 6, 1'b0, 32'h1234_5678, 4);
        tbl[2]  = mkv(32'h1A10_0008, 1'b1, 32'h0,         4'h0, 0,   32'h0000_55AA, 1'b1, 3, 1'b1, ERR,           1);
        tbl[3]  = mkv(32'h1A20_0000, 1'b1, 32'h0,         4'h0, 0,   32'h0,         1'b0, 1, 1'b1, ERR,           0);
        tbl[4]  = mkv(32'h1A0F_FFFC, 1'b0, 32'h1111_2222, 4'h3, 0,   32'h0,         1'b0, 1, 1'b1, 32'h0,         0);
        tbl[5]  = mkv(32'h1A1F_FFFC, 1'b1, 32'h0,         4'h0, 1,   32'hDEAD_BEEF, 1'b0, 4, 1'b0, 32'hDEAD_BEEF, 2);
        tbl[6]  = mkv(32'h1A10_0000, 1'b0, 32'h5555_AAAA, 4'h0, 0,   32'h0,         1'b0, 3, 1'b0, 32'h0,         1);
        tbl[7]  = mkv(32'h1A10_0020, 1'b1, 32'h0,         4'h0, 100, 32'h7777_7777, 1'b0, 6, 1'b1, ERR,           4);
        tbl[8]  = mkv(32'h1A10_0024, 1'b0, 32'h0BAD_F00D, 4'hC, 100, 32'h0,         1'b0, 6, 1'b1, 32'h0,         4);
        tbl[9]  = mkv(32'h1A10_0028, 1'b0, 32'h8765_4321, 4'h5, 2,   32'h0,         1'b1, 5, 1'b1, 32'h0,         3);
        tbl[10] = mkv(32'hFFFF_FFFC, 1'b1, 32'h0,         4'h0, 0,   32'h0,         1'b0, 1, 1'b1, ERR,           0);

        rst = 1'b1; req = 1'b0; add = '0; wen = 1'b0; wdata = '0; be = '0;
        #3;
        check("rst gnt",     {31'd0, gnt},     32'd0);
        check("rst r_valid", {31'd0, r_valid}, 32'd0);
        check("rst r_rdata", r_rdata,          32'd0);
        check("rst r_opc",   {31'd0, r_opc},   32'd0);
        check("rst psel",    {31'd0, psel},    32'd0);
        check("rst penable", {31'd0, penable}, 32'd0);
        check("rst pwrite",  {31'd0, pwrite},  32'd0);
        check("rst paddr",   paddr,            32'd0);
        check("rst pwdata",  pwdata,           32'd0);
        check("rst pstrb",   {28'd0, pstrb},   32'd0);
        check("rst pprot",   {29'd0, pprot},   32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            if (i == 7) late_pulse = 1'b1;   // stray pready around the timed-out read
            run_and_check($sformatf("vec%0d", i), tbl[i].t, tbl[i].e);
            if (i == 7) begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("late_pready no_rvalid", {31'd0, r_valid}, 32'd0);
                    check("late_pready no_psel",   {31'd0, psel},    32'd0);
                end
                late_pulse = 1'b0;
            end
        end

        // Back-to-back writes with req held: second gnt only after first r_valid.
        gnt_e = 8'b0001_0001; psel_e = 8'b0110_0110; rv_e = 8'b1000_1000;
        resp_waits = 0; resp_slverr = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; add = 32'h1A10_0040; wen = 1'b0; wdata = 32'h1111_1111; be = 4'hF;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("b2b gnt c%0d", c),     {31'd0, gnt},     {31'd0, gnt_e[c]});
            check($sformatf("b2b psel c%0d", c),    {31'd0, psel},    {31'd0, psel_e[c]});
            check($sformatf("b2b r_valid c%0d", c), {31'd0, r_valid}, {31'd0, rv_e[c]});
            if (c == 6) check("b2b second paddr", paddr, 32'h1A10_0044);
            if (c == 7) check("b2b r_opc", {31'd0, r_opc}, 32'd0);
            @(posedge clk); #1;
            if (c == 0) begin add = 32'h1A10_0044; wdata = 32'h2222_2222; end
            if (c == 4) req = 1'b0;
        end

        // Reset while in ACCESS aborts the transfer at once.
        resp_waits = 100;
        @(posedge clk); #1;
        req = 1'b1; add = 32'h1A10_0050; wen = 1'b1;
        @(negedge clk);
        check("rst_mid gnt", {31'd0, gnt}, 32'd1);
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        check("rst_mid in_access", {31'd0, psel && penable}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid psel",    {31'd0, psel},    32'd0);
        check("rst_mid penable", {31'd0, penable}, 32'd0);
        check("rst_mid r_valid", {31'd0, r_valid}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        t = '{add: 32'h1A10_0054, wen: 1'b1, wdata: 32'h0, be: 4'h0, waits: 1,
              prdata: 32'hA5A5_0F0F, slverr: 1'b0};
        run_and_check("after_rst", t, model(t));

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) t.add = $urandom;
            else                           t.add = BASE + ($urandom & 32'h000F_FFFC);
            t.wen    = $urandom_range(0, 1) == 1;
            t.wdata  = $urandom;
            t.be     = 4'($urandom);
            t.waits  = $urandom_range(0, 5);
            t.prdata = $urandom;
            t.slverr = $urandom_range(0, 3) == 0;
            run_and_check($sformatf("rnd%0d", i), t, model(t));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/tcdm_to_apb_bridge.md
Name: tcdm_to_apb_bridge

Overview:
- Single-port TCDM/lint responder that turns each granted 32-bit TCDM request into one APB3/APB4 transfer to a peripheral.
- Returns the result as a TCDM response.
- Sits behind a contiguous-crossbar slave port of the SoC interconnect, giving TCDM masters a low-latency path to peripherals without the AXI/AXI-lite conversion chain.
- Handles one transaction at a time, with address-window checking and a pready timeout.

Parameters:
ADDR_WIDTH, 32, width of the TCDM address and paddr.
DATA_WIDTH, 32, width of wdata, rdata, pwdata and prdata; only 32 is supported.
BASE_ADDR, 32'h1A10_0000, first byte address decoded by the bridge.
WINDOW_SIZE, 32'h0010_0000, size of the decoded window in bytes.
TIMEOUT_CYCLES, 255, maximum ACCESS cycles waiting for pready; 0 disables the timeout.
ERR_RDATA, 32'hBADA_CCE5, r_rdata value returned on a read error.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
tcdm_req_i  in  1  TCDM request
tcdm_add_i  in  ADDR_WIDTH  byte address
tcdm_wen_i  in  1  1 = read, 0 = write
tcdm_wdata_i  in  DATA_WIDTH  write data
tcdm_be_i  in  DATA_WIDTH/8  byte enables
tcdm_gnt_o  out  1  grant
tcdm_r_valid_o  out  1  response valid
tcdm_r_rdata_o  out  DATA_WIDTH  read data
tcdm_r_opc_o  out  1  response error
paddr_o  out  ADDR_WIDTH  APB address
pwrite_o  out  1  APB write
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwdata_o  out  DATA_WIDTH  APB write data
pstrb_o  out  DATA_WIDTH/8  APB strobes
pprot_o  out  3  APB protection, tied to 3'b000
pready_i  in  1  APB ready
prdata_i  in  DATA_WIDTH  APB read data
pslverr_i  in  1  APB slave error

Behaviour:
- Clocking and reset: one clock clk_i; reset rst_i is asynchronous, active-high.
- On reset, all registered outputs are 0: r_valid, r_rdata, r_opc, psel, penable, pwrite, paddr, pwdata, pstrb. The FSM goes to IDLE and the timeout counter clears.
- Reset asserted mid-transfer aborts it immediately: psel and penable drop and no response is issued.

FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: tcdm_gnt_o = tcdm_req_i, combinationally; gnt is 0 in every other state. On req&gnt at cycle T, register add, wen, wdata and be.
  - Address in window (BASE_ADDR <= add < BASE_ADDR+WINDOW_SIZE, compared in ADDR_WIDTH+1 bits, so no wrap-around) -> SETUP.
  - Address outside window -> RESP with error.
- SETUP (cycle T+1): psel=1, penable=0, paddr=add, pwrite=~wen. For writes, pwdata=wdata and pstrb=be; for reads, pstrb=0. Always -> ACCESS.
- ACCESS (T+2 onward): psel=1, penable=1, with address, control and data held stable. The counter increments each cycle pready_i=0.
  - pready_i=1: capture prdata (reads) and pslverr, then -> RESP.
  - Counter reaches TIMEOUT_CYCLES with pready still 0 (TIMEOUT_CYCLES != 0): -> RESP with error. psel and penable drop the next cycle, and a late pready is ignored.
- RESP: tcdm_r_valid_o=1 for exactly one cycle, then -> IDLE; the next grant is possible in the following cycle.
  - r_opc = pslverr | timeout | out-of-window.
  - r_rdata: prdata on a successful read; ERR_RDATA on a read error; 0 for all writes.
  - Writes also produce r_valid.
- Minimum latency, gnt to r_valid: 3 cycles for in-window with zero wait states; 1 cycle for out-of-window.
- Throughput: at most one outstanding transaction. A new req while busy sees gnt=0 and must be held by the master.
- r_rdata and r_opc hold their last values after r_valid drops.
- be=0 write: APB transfer still issued with pstrb=0.
- Checker: the bench flags psel deasserted without a completed or timed-out access.

Test Plan:
- Write add=32'h1A10_0010, wdata=32'hCAFE_F00D, be=4'hF, pready=1 immediately -> gnt at T; psel at T+1; penable at T+2 with paddr=32'h1A10_0010, pwrite=1, pstrb=4'hF; r_valid at T+3 with r_opc=0, r_rdata=0.
- Read add=32'h1A10_0004, prdata=32'h1234_5678, pready after 3 wait states -> r_valid at T+6, r_rdata=32'h1234_5678, r_opc=0.
- Read with pslverr=1 at pready -> r_opc=1, r_rdata=32'hBADA_CCE5. Read at add=32'h1A20_0000 (out of window) -> no psel, r_valid at T+1, r_opc=1.
- TIMEOUT_CYCLES=4, pready held 0 -> exactly 4 ACCESS cycles, psel drops, r_valid with r_opc=1. A later pready pulse produces no extra r_valid.
- Back-to-back: req held high for two writes -> second gnt only in the cycle after the first r_valid; no overlap of psel between transfers.
- Assert rst_i during ACCESS -> psel, penable and r_valid are 0 immediately; after release, a new read completes normally.
